keypad_emulator: RTL and testbench
==================================

Name: keypad_emulator

Overview:
- Synthesizable model of a 4x4 matrix keypad with mechanical contact bounce: the other end of the row-drive/column-sense interface used by keypad_scanner.
- Accepts "press key K for N cycles" commands and drives column lines according to the scanner's row drive.
- Used as an on-FPGA loopback/self-test source for the scanner/debouncer/decoder/controller chain and as a deterministic bench stimulus.

Parameters:
- BOUNCE_TOGGLES, 4: contact bounce cycles (closed/open pairs) on press and on release; 0 disables bounce.
- BOUNCE_HALF, 8: clk cycles per bounce half-period; must be >= 1.
- HOLD_W, 16: width of the hold-time field.

Ports:
- clk  input  1  system clock (3 MHz in hardware).
- rst_n  input  1  asynchronous, active-low reset.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high when a command can be accepted.
- cmd_key  input  4  hex key code 0x0-0xF to press.
- cmd_hold  input  HOLD_W  stable-closed hold time in clk cycles.
- abort  input  1  forces immediate release and return to IDLE.
- keypad_rows  input  4  scanner row drive; active-low, one row low at a time.
- keypad_cols  output  4  column lines; active-low, idle 4'b1111.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse when a press/release sequence completes normally.

Behaviour:
- Key layout (row,col), row/col index = bit index:
  - row0: 1 2 3 A
  - row1: 4 5 6 B
  - row2: 7 8 9 C
  - row3: E 0 F D
- Latched key maps to key_row and key_col.
- Column output is combinational from keypad_rows and the registered contact state, with zero latency:
  - keypad_cols[key_col] = 0 iff contact is closed and keypad_rows[key_row] = 0.
  - All other column bits are always 1.
  - Multiple rows low (illegal drive) follows the same rule. All rows high gives 4'b1111.
- Reset (asynchronous, rst_n=0):
  - state=IDLE, contact open, keypad_cols=4'b1111.
  - cmd_ready=1, busy=0, done=0.
  - Latched key=0, all counters=0.
- Handshake: cmd_ready = (state==IDLE). The command is accepted on the rising edge where cmd_valid && cmd_ready. cmd_key and cmd_hold are latched on that edge. cmd_hold=0 is treated as 1.
- FSM (accept edge = cycle T):
  - IDLE: contact open. On accept, go to PRESS_BOUNCE.
  - PRESS_BOUNCE:
    - Lasts 2*BOUNCE_TOGGLES*BOUNCE_HALF cycles (64 at defaults).
    - Contact is closed in even-numbered half-periods (starting T+1) and open in odd ones.
    - Then go to HOLD. If BOUNCE_TOGGLES=0, go straight to HOLD at T+1.
  - HOLD: contact closed for exactly the latched hold cycles, then go to RELEASE_BOUNCE.
  - RELEASE_BOUNCE: same length as PRESS_BOUNCE. Contact is open in even half-periods and closed in odd ones. Then go to DONE.
  - DONE: one cycle, contact open, done=1. Next cycle go to IDLE (cmd_ready=1).
- abort:
  - Sampled each edge. In any non-IDLE state, abort=1 gives contact open and state IDLE on the next cycle.
  - No done pulse is generated.
  - Ignored in IDLE. abort has priority over a normal state advance on the same edge.
- cmd_valid while busy is ignored (no queueing). The command is not accepted until cmd_ready is high.
- Counters:
  - The half-period counter runs 0..BOUNCE_HALF-1.
  - The half-period index runs 0..2*BOUNCE_TOGGLES-1.
  - The hold counter is HOLD_W bits.
  - All counters clear on every state entry. There is no wrap-around inside a phase.
- Reset asserted mid-sequence immediately opens the contact (cols=4'b1111) and returns to IDLE. No done pulse is generated.

Test Plan:
1. Reset, then cmd_key=0x5, cmd_hold=100, rows cycling 1110/1101/1011/0111 each cycle. Required response:
   - cmd_ready low T+1..T+229, done=1 exactly at T+229, cmd_ready high at T+230.
   - cols=1101 only when rows=1101 and contact is closed. Contact is closed T+1..T+8, open T+9..T+16, …, and closed continuously T+65..T+164.
   - cols=1111 for every other row.
2. Sweep all 16 keys with rows held at each one-cold value and hold=20:
   - Only the mapped column is low, only for the mapped row. Examples: 0x0 → rows=0111 gives cols=1101; 0xD → rows=0111 gives cols=0111.
3. BOUNCE_TOGGLES=0, key 0xA, hold=0:
   - Contact closed exactly 1 cycle (T+1).
   - done at T+2.
4. abort asserted at T+70 (during HOLD):
   - Contact open from T+71, cols=1111, state IDLE, cmd_ready=1.
   - done never pulses.
   - cmd_valid held high throughout is not re-accepted before T+71.
5. rst_n low asynchronously at T+30 (mid PRESS_BOUNCE):
   - keypad_cols=1111 and busy=0 immediately, without waiting for a clk edge.
   - After release of rst_n, a new command is accepted normally.
6. Back-to-back commands with cmd_valid held high:
   - The second command is accepted on the edge where cmd_ready returns (T+230), with its key and hold latched then.

Source files
------------

// File: rtl/keypad_emulator.sv
// keypad_emulator: 4x4 matrix keypad model with contact bounce, driven by
// "press key K for N cycles" commands. It answers a row-scanning keypad
// controller on the column lines.
//
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   cmd_valid     command request (accepted when cmd_ready is high)
//   cmd_ready     high while idle
//   cmd_key       hex key code to press
//   cmd_hold      stable-closed hold time in clk cycles (0 behaves as 1)
//   abort         immediate release and return to idle (ignored when idle)
//   keypad_rows   scanner row drive, active-low
//   keypad_cols   column lines, active-low; combinational from rows + contact
//   busy          high whenever not idle
//   done          one-cycle pulse when a sequence completes normally
module keypad_emulator #(
    parameter int unsigned BOUNCE_TOGGLES = 4,
    parameter int unsigned BOUNCE_HALF    = 8,
    parameter int unsigned HOLD_W         = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [3:0]        cmd_key,
    input  logic [HOLD_W-1:0] cmd_hold,
    input  logic              abort,
    input  logic [3:0]        keypad_rows,
    output logic [3:0]        keypad_cols,
    output logic              busy,
    output logic              done
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_PRESS = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_REL   = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    localparam int unsigned PHASES = (BOUNCE_TOGGLES == 0) ? 1 : 2 * BOUNCE_TOGGLES;
    localparam int unsigned IDX_W  = (PHASES > 1) ? $clog2(PHASES) : 1;
    localparam int unsigned HALF_W = (BOUNCE_HALF > 1) ? $clog2(BOUNCE_HALF) : 1;

    localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(PHASES - 1);
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BOUNCE_HALF - 1);
    localparam logic              BOUNCE_EN = (BOUNCE_TOGGLES != 0);

    logic [2:0]        state_q, state_d;
    logic [3:0]        key_q, key_d;
    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic [HALF_W-1:0] half_q, half_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic              contact_q, contact_d;
    logic              ready_q, ready_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;

    logic [1:0]        key_row;
    logic [1:0]        key_col;
    logic              bounce_last;

    // Last cycle of the last half-period of a bounce phase.
    assign bounce_last = (half_q == HALF_LAST) && (idx_q == IDX_LAST);

    // Next-state, counter and contact logic.
    always_comb begin
        state_d    = state_q;
        key_d      = key_q;
        hold_d     = hold_q;
        hold_cnt_d = hold_cnt_q;
        half_d     = half_q;
        idx_d      = idx_q;
        contact_d  = 1'b0;
        ready_d    = 1'b0;
        busy_d     = 1'b0;
        done_d     = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    key_d   = cmd_key;
                    hold_d  = (cmd_hold == '0) ? HOLD_W'(1) : cmd_hold;
                    state_d = BOUNCE_EN ? S_PRESS : S_HOLD;
                end
            end
            S_PRESS, S_REL: begin
                if (half_q == HALF_LAST) begin
                    half_d = '0;
                    idx_d  = idx_q + IDX_W'(1);
                end else begin
                    half_d = half_q + HALF_W'(1);
                end
                if (bounce_last) begin
                    state_d = (state_q == S_PRESS) ? S_HOLD : S_DONE;
                end
            end
            S_HOLD: begin
                hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                if (hold_cnt_q == hold_q - HOLD_W'(1)) begin
                    state_d = BOUNCE_EN ? S_REL : S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
        end

        // Every phase starts its counters from zero.
        if (state_d != state_q) begin
            hold_cnt_d = '0;
            half_d     = '0;
            idx_d      = '0;
        end

        // Press bounce closes on even half-periods, release bounce on odd ones.
        case (state_d)
            S_PRESS: contact_d = ~idx_d[0];
            S_HOLD:  contact_d = 1'b1;
            S_REL:   contact_d = idx_d[0];
            default: contact_d = 1'b0;
        endcase

        ready_d = (state_d == S_IDLE);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            key_q      <= 4'h0;
            hold_q     <= '0;
            hold_cnt_q <= '0;
            half_q     <= '0;
            idx_q      <= '0;
            contact_q  <= 1'b0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            key_q      <= key_d;
            hold_q     <= hold_d;
            hold_cnt_q <= hold_cnt_d;
            half_q     <= half_d;
            idx_q      <= idx_d;
            contact_q  <= contact_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    // Keypad layout: key code to {row, col}.
    always_comb begin
        key_row = 2'd0;
        key_col = 2'd0;
        case (key_q)
            4'h1: begin key_row = 2'd0; key_col = 2'd0; end
            4'h2: begin key_row = 2'd0; key_col = 2'd1; end
            4'h3: begin key_row = 2'd0; key_col = 2'd2; end
            4'hA: begin key_row = 2'd0; key_col = 2'd3; end
            4'h4: begin key_row = 2'd1; key_col = 2'd0; end
            4'h5: begin key_row = 2'd1; key_col = 2'd1; end
            4'h6: begin key_row = 2'd1; key_col = 2'd2; end
            4'hB: begin key_row = 2'd1; key_col = 2'd3; end
            4'h7: begin key_row = 2'd2; key_col = 2'd0; end
            4'h8: begin key_row = 2'd2; key_col = 2'd1; end
            4'h9: begin key_row = 2'd2; key_col = 2'd2; end
            4'hC: begin key_row = 2'd2; key_col = 2'd3; end
            4'hE: begin key_row = 2'd3; key_col = 2'd0; end
            4'h0: begin key_row = 2'd3; key_col = 2'd1; end
            4'hF: begin key_row = 2'd3; key_col = 2'd2; end
            4'hD: begin key_row = 2'd3; key_col = 2'd3; end
            default: begin key_row = 2'd0; key_col = 2'd0; end
        endcase
    end

    // Zero-latency column response, as a real switch contact would give.
    always_comb begin
        keypad_cols = 4'b1111;
        if (contact_q && !keypad_rows[key_row]) begin
            keypad_cols[key_col] = 1'b0;
        end
    end

    assign cmd_ready = ready_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_emulator.sv
module tb_keypad_emulator;

    localparam int TOG  = 4;
    localparam int HALF = 8;
    localparam int PB   = 2 * TOG * HALF;

    typedef struct {
        logic [3:0] cols;
        logic       rdy;
        logic       dn;
        logic       bsy;
    } exp_t;

    typedef struct {
        logic [3:0] key;
        logic [3:0] rows;
        logic [3:0] cols;
    } vec_t;

    logic        clk;
    logic        rst_n;
    logic        cmd_valid, cmd_ready, abort, busy, done;
    logic [3:0]  cmd_key, keypad_rows, keypad_cols;
    logic [15:0] cmd_hold;

    logic        v0, rdy0, ab0, busy0, done0;
    logic [3:0]  k0, rows0, cols0;
    logic [15:0] h0;

    int checks   = 0;
    int failures = 0;
    exp_t sb_q[$];

    keypad_emulator u_dut (
        .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_key(cmd_key), .cmd_hold(cmd_hold), .abort(abort),
        .keypad_rows(keypad_rows), .keypad_cols(keypad_cols), .busy(busy), .done(done)
    );

    keypad_emulator #(.BOUNCE_TOGGLES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .cmd_valid(v0), .cmd_ready(rdy0),
        .cmd_key(k0), .cmd_hold(h0), .abort(ab0),
        .keypad_rows(rows0), .keypad_cols(cols0), .busy(busy0), .done(done0)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // {row, col} of each key in the keypad layout.
    function automatic logic [3:0] key_rc(input logic [3:0] key);
        case (key)
            4'h1: return {2'd0, 2'd0};  4'h2: return {2'd0, 2'd1};
            4'h3: return {2'd0, 2'd2};  4'hA: return {2'd0, 2'd3};
            4'h4: return {2'd1, 2'd0};  4'h5: return {2'd1, 2'd1};
            4'h6: return {2'd1, 2'd2};  4'hB: return {2'd1, 2'd3};
            4'h7: return {2'd2, 2'd0};  4'h8: return {2'd2, 2'd1};
            4'h9: return {2'd2, 2'd2};  4'hC: return {2'd2, 2'd3};
            4'hE: return {2'd3, 2'd0};  4'h0: return {2'd3, 2'd1};
            4'hF: return {2'd3, 2'd2};  default: return {2'd3, 2'd3};
        endcase
    endfunction

    function automatic logic [3:0] exp_cols(input logic [3:0] key, input logic [3:0] rows,
                                            input logic c);
        logic [3:0] rc;
        logic [3:0] v;
        rc = key_rc(key);
        v  = 4'b1111;
        if (c && (rows[rc[3:2]] == 1'b0)) v[rc[1:0]] = 1'b0;
        return v;
    endfunction

    // Expected contact state in cycle T+k for a sequence with hold h.
    function automatic logic exp_contact(input int k, input int h);
        if (k < 1) return 1'b0;
        if (k <= PB) return (((k - 1) / HALF) % 2) == 0;
        if (k <= PB + h) return 1'b1;
        if (k <= 2 * PB + h) return (((k - PB - h - 1) / HALF) % 2) == 1;
        return 1'b0;
    endfunction

    // Called 1 time unit after an edge; returns 1 time unit after the accept edge.
    task automatic issue(input logic [3:0] key, input logic [15:0] hold, input bit keep);
        int n;
        cmd_key   = key;
        cmd_hold  = hold;
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 400) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 400) check("issue_timeout", 32'd0, 32'd1);
        @(posedge clk); #1;
        if (!keep) cmd_valid = 1'b0;
    endtask

    // Cycle-by-cycle checked run: k=1 is the first cycle after the accept edge.
    task automatic run_seq(input logic [3:0] key, input int h, input int n,
                           input int abort_k, input int rows_fixed);
        exp_t e, got;
        logic [3:0] cyc [4];
        int hold_eff;
        cyc[0] = 4'b1110; cyc[1] = 4'b1101; cyc[2] = 4'b1011; cyc[3] = 4'b0111;
        hold_eff = (h == 0) ? 1 : h;
        for (int k = 1; k <= n; k++) begin
            keypad_rows = (rows_fixed < 0) ? cyc[(k - 1) % 4] : 4'(rows_fixed);
            abort = (k == abort_k);
            if (abort_k > 0 && k > abort_k) begin
                e.cols = 4'b1111; e.rdy = 1'b1; e.dn = 1'b0; e.bsy = 1'b0;
            end else begin
                e.cols = exp_cols(key, keypad_rows, exp_contact(k, hold_eff));
                e.dn   = (k == 2 * PB + hold_eff + 1);
                e.rdy  = (k > 2 * PB + hold_eff + 1);
                e.bsy  = !e.rdy;
            end
            sb_q.push_back(e);
            @(negedge clk);
            got = sb_q.pop_front();
            check("seq_cols",  32'(keypad_cols), 32'(got.cols));
            check("seq_ready", 32'(cmd_ready),   32'(got.rdy));
            check("seq_done",  32'(done),        32'(got.dn));
            check("seq_busy",  32'(busy),        32'(got.bsy));
            @(posedge clk); #1;
        end
        abort = 1'b0;
    endtask

    vec_t tbl [16];
    logic [3:0] pats [6];

    initial begin
        exp_t e, got;
        tbl[0]  = '{4'h1, 4'b1110, 4'b1110}; tbl[1]  = '{4'h2, 4'b1110, 4'b1101};
        tbl[2]  = '{4'h3, 4'b1110, 4'b1011}; tbl[3]  = '{4'hA, 4'b1110, 4'b0111};
        tbl[4]  = '{4'h4, 4'b1101, 4'b1110}; tbl[5]  = '{4'h5, 4'b1101, 4'b1101};
        tbl[6]  = '{4'h6, 4'b1101, 4'b1011}; tbl[7]  = '{4'hB, 4'b1101, 4'b0111};
        tbl[8]  = '{4'h7, 4'b1011, 4'b1110}; tbl[9]  = '{4'h8, 4'b1011, 4'b1101};
        tbl[10] = '{4'h9, 4'b1011, 4'b1011}; tbl[11] = '{4'hC, 4'b1011, 4'b0111};
        tbl[12] = '{4'hE, 4'b0111, 4'b1110}; tbl[13] = '{4'h0, 4'b0111, 4'b1101};
        tbl[14] = '{4'hF, 4'b0111, 4'b1011}; tbl[15] = '{4'hD, 4'b0111, 4'b0111};
        pats[0] = 4'b1110; pats[1] = 4'b1101; pats[2] = 4'b1011;
        pats[3] = 4'b0111; pats[4] = 4'b1111; pats[5] = 4'b0000;

        rst_n = 1'b1; cmd_valid = 1'b0; cmd_key = 4'h0; cmd_hold = 16'd0;
        abort = 1'b0; keypad_rows = 4'b0000;
        v0 = 1'b0; k0 = 4'h0; h0 = 16'd0; ab0 = 1'b0; rows0 = 4'b0000;

        // Reset state
        #1 rst_n = 1'b0;
        #2;
        check("rst_cols",  32'(keypad_cols), 32'hF);
        check("rst_ready", 32'(cmd_ready),   32'd1);
        check("rst_busy",  32'(busy),        32'd0);
        check("rst_done",  32'(done),        32'd0);
        check("rst_ready0", 32'(rdy0),       32'd1);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;

        // Full sequence, key 5, hold 100, rows scanning
        issue(4'h5, 16'd100, 1'b0);
        run_seq(4'h5, 100, 231, 0, -1);

        // Key sweep in HOLD across all row patterns, then abort
        for (int i = 0; i < 16; i++) begin
            issue(tbl[i].key, 16'd20, 1'b0);
            repeat (PB) @(posedge clk);
            #1;
            for (int j = 0; j < 6; j++) begin
                keypad_rows = pats[j];
                e.cols = (pats[j] == tbl[i].rows || pats[j] == 4'b0000) ? tbl[i].cols : 4'b1111;
                e.rdy = 1'b0; e.dn = 1'b0; e.bsy = 1'b1;
                sb_q.push_back(e);
                @(negedge clk);
                got = sb_q.pop_front();
                check("sweep_cols", 32'(keypad_cols), 32'(got.cols));
                check("sweep_busy", 32'(busy),        32'(got.bsy));
                @(posedge clk); #1;
            end
            abort = 1'b1;
            @(posedge clk); #1;
            abort = 1'b0;
            @(negedge clk);
            check("sweep_abort_cols",  32'(keypad_cols), 32'hF);
            check("sweep_abort_ready", 32'(cmd_ready),   32'd1);
            check("sweep_abort_done",  32'(done),        32'd0);
            @(posedge clk); #1;
        end

        // No-bounce instance, key A, hold 0
        v0 = 1'b1; k0 = 4'hA; h0 = 16'd0; rows0 = 4'b1110;
        @(posedge clk); #1;
        v0 = 1'b0;
        @(negedge clk);
        check("nb_cols_t1", 32'(cols0), 32'h7);
        check("nb_busy_t1", 32'(busy0), 32'd1);
        check("nb_done_t1", 32'(done0), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("nb_cols_t2", 32'(cols0), 32'hF);
        check("nb_done_t2", 32'(done0), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("nb_ready_t3", 32'(rdy0), 32'd1);
        check("nb_done_t3",  32'(done0), 32'd0);
        @(posedge clk); #1;

        // Abort in HOLD with cmd_valid held high and cmd_key changed
        issue(4'h5, 16'd100, 1'b1);
        cmd_key = 4'h3; cmd_hold = 16'd7;
        run_seq(4'h5, 100, 71, 70, -1);
        cmd_valid = 1'b0;
        @(negedge clk);
        check("abort_reaccept_busy", 32'(busy), 32'd1);
        @(posedge clk); #1;
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        @(negedge clk);
        check("abort2_ready", 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;

        // Asynchronous reset mid press-bounce, contact closed
        issue(4'h5, 16'd100, 1'b0);
        keypad_rows = 4'b1101;
        repeat (32) @(posedge clk);
        #1;
        check("prerst_cols", 32'(keypad_cols), 32'hD);
        check("prerst_busy", 32'(busy),        32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("asyncrst_cols",  32'(keypad_cols), 32'hF);
        check("asyncrst_busy",  32'(busy),        32'd0);
        check("asyncrst_ready", 32'(cmd_ready),   32'd1);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        issue(4'h5, 16'd5, 1'b0);
        run_seq(4'h5, 5, 136, 0, -1);

        // Back-to-back commands with cmd_valid held high
        issue(4'h5, 16'd10, 1'b1);
        cmd_key = 4'h9; cmd_hold = 16'd30;
        run_seq(4'h5, 10, 140, 0, -1);
        cmd_valid = 1'b0;
        run_seq(4'h9, 30, 161, 0, -1);

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #600000;
        failures++;
        $display("FAIL watchdog: got timeout expected completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
